// File: rtl/dm_arb_pkg.sv
// Shared widths, address limit, FSM encoding and port identifiers for the data-memory arbiter.
// Pure declarations: no latency, no flow control.
package dm_arb_pkg;

    localparam int DM_ADDR_W = 16;
    localparam int DM_DATA_W = 32;
    localparam logic [DM_ADDR_W-1:0] DM_LAST_ADDR = 16'hFFFC;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_WE    = 2'd2,
        ST_WDONE = 2'd3
    } dm_state_e;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } dm_port_e;

    function automatic logic dm_in_range(input logic [DM_ADDR_W-1:0] addr);
        return (addr <= DM_LAST_ADDR);
    endfunction

endpackage

// File: rtl/dm_arb_if.sv
// One requester port of the arbiter: req/we/addr/wdata in, gnt and completion pulses out.
// Requester holds req until gnt; gnt is the only backpressure.
interface dm_arb_if;

    logic                            req;
    logic                            we;
    logic [dm_arb_pkg::DM_ADDR_W-1:0] addr;
    logic [dm_arb_pkg::DM_DATA_W-1:0] wdata;
    logic                            gnt;
    logic [dm_arb_pkg::DM_DATA_W-1:0] rdata;
    logic                            rvalid;
    logic                            done;
    logic                            err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rdata, rvalid, done, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rdata, rvalid, done, err
    );

endinterface

// File: rtl/dm_arb_rr_pick.sv
// Two-way pick: one-hot {B,A} from the two requests, the last grantee and the fairness mode.
// Combinational, zero latency; a zero result means nobody is requesting.
module dm_rr_pick #(
    parameter bit FAIR = 1'b1
) (
    input  logic       i_req_a,
    input  logic       i_req_b,
    input  logic       i_last_b,
    output logic [1:0] o_pick
);

    always_comb begin
        o_pick = 2'b00;
        if (i_req_a && i_req_b) begin
            // Fixed priority ignores history; fair mode hands a tie to whoever lost last time.
            if (FAIR && !i_last_b) begin
                o_pick = 2'b10;
            end else begin
                o_pick = 2'b01;
            end
        end else if (i_req_a) begin
            o_pick = 2'b01;
        end else if (i_req_b) begin
            o_pick = 2'b10;
        end
    end

endmodule

// File: rtl/dm_arb.sv
// Arbitrates two requesters onto one single-ported data memory; read: gnt k, rvalid k+1; write: gnt k, done k+1, idle k+2.
// Requests are only sampled in IDLE; the loser simply keeps req high and is served next.
module dm_arb
    import dm_arb_pkg::*;
#(
    parameter bit FAIR = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    dm_arb_if.slave              a_port,
    dm_arb_if.slave              b_port,
    output logic [DM_ADDR_W-1:0] dm_read_addr,
    output logic [DM_ADDR_W-1:0] dm_write_addr,
    output logic [DM_DATA_W-1:0] dm_write_data,
    output logic                 dm_we,
    input  logic [DM_DATA_W-1:0] dm_read_data
);

    logic [1:0]           w_pick;
    logic                 w_any;
    dm_port_e             w_sel_port;
    logic                 w_sel_we;
    logic [DM_ADDR_W-1:0] w_sel_addr;
    logic [DM_DATA_W-1:0] w_sel_wdata;
    logic                 w_sel_ok;

    dm_state_e            r_state;
    dm_port_e             r_last;
    dm_port_e             r_owner;
    logic                 r_oor;
    logic                 r_a_gnt, r_a_rvalid, r_a_done, r_a_err;
    logic                 r_b_gnt, r_b_rvalid, r_b_done, r_b_err;
    logic [DM_DATA_W-1:0] r_a_rdata, r_b_rdata;
    logic [DM_ADDR_W-1:0] r_dm_read_addr;
    logic [DM_ADDR_W-1:0] r_dm_write_addr;
    logic [DM_DATA_W-1:0] r_dm_write_data;
    logic                 r_dm_we;

    dm_rr_pick #(.FAIR(FAIR)) u_pick (
        .i_req_a  (a_port.req),
        .i_req_b  (b_port.req),
        .i_last_b (r_last == PORT_B),
        .o_pick   (w_pick)
    );

    assign w_any       = |w_pick;
    assign w_sel_port  = w_pick[1] ? PORT_B : PORT_A;
    assign w_sel_we    = w_pick[1] ? b_port.we    : a_port.we;
    assign w_sel_addr  = w_pick[1] ? b_port.addr  : a_port.addr;
    assign w_sel_wdata = w_pick[1] ? b_port.wdata : a_port.wdata;
    assign w_sel_ok    = dm_in_range(w_sel_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_last          <= PORT_B;
            r_owner         <= PORT_A;
            r_oor           <= 1'b0;
            r_a_gnt         <= 1'b0;
            r_a_rvalid      <= 1'b0;
            r_a_done        <= 1'b0;
            r_a_err         <= 1'b0;
            r_b_gnt         <= 1'b0;
            r_b_rvalid      <= 1'b0;
            r_b_done        <= 1'b0;
            r_b_err         <= 1'b0;
            r_a_rdata       <= '0;
            r_b_rdata       <= '0;
            r_dm_we         <= 1'b0;
            r_dm_read_addr  <= '0;
            // A write caught mid-pulse keeps addr/data for the cycle in which dm_we falls, so it still lands.
            if (r_state != ST_WE) begin
                r_dm_write_addr <= '0;
                r_dm_write_data <= '0;
            end
        end else begin
            r_a_gnt    <= 1'b0;
            r_a_rvalid <= 1'b0;
            r_a_done   <= 1'b0;
            r_a_err    <= 1'b0;
            r_b_gnt    <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_b_done   <= 1'b0;
            r_b_err    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_last  <= w_sel_port;
                        r_owner <= w_sel_port;
                        r_oor   <= !w_sel_ok;
                        if (w_sel_port == PORT_B) begin
                            r_b_gnt <= 1'b1;
                        end else begin
                            r_a_gnt <= 1'b1;
                        end
                        // Out-of-range requests walk the normal states but never touch the memory port.
                        if (w_sel_we) begin
                            r_state <= ST_WE;
                            if (w_sel_ok) begin
                                r_dm_we         <= 1'b1;
                                r_dm_write_addr <= w_sel_addr;
                                r_dm_write_data <= w_sel_wdata;
                            end
                        end else begin
                            r_state <= ST_RD;
                            if (w_sel_ok) begin
                                r_dm_read_addr <= w_sel_addr;
                            end
                        end
                    end
                end
                ST_RD: begin
                    r_state <= ST_IDLE;
                    if (r_oor) begin
                        if (r_owner == PORT_B) r_b_err <= 1'b1;
                        else                   r_a_err <= 1'b1;
                    end else if (r_owner == PORT_B) begin
                        r_b_rdata  <= dm_read_data;
                        r_b_rvalid <= 1'b1;
                    end else begin
                        r_a_rdata  <= dm_read_data;
                        r_a_rvalid <= 1'b1;
                    end
                end
                ST_WE: begin
                    r_state <= ST_WDONE;
                    r_dm_we <= 1'b0;
                    if (r_oor) begin
                        if (r_owner == PORT_B) r_b_err <= 1'b1;
                        else                   r_a_err <= 1'b1;
                    end else begin
                        if (r_owner == PORT_B) r_b_done <= 1'b1;
                        else                   r_a_done <= 1'b1;
                    end
                end
                ST_WDONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign a_port.gnt    = r_a_gnt;
    assign a_port.rvalid = r_a_rvalid;
    assign a_port.done   = r_a_done;
    assign a_port.err    = r_a_err;
    assign a_port.rdata  = r_a_rdata;
    assign b_port.gnt    = r_b_gnt;
    assign b_port.rvalid = r_b_rvalid;
    assign b_port.done   = r_b_done;
    assign b_port.err    = r_b_err;
    assign b_port.rdata  = r_b_rdata;

    assign dm_read_addr  = r_dm_read_addr;
    assign dm_write_addr = r_dm_write_addr;
    assign dm_write_data = r_dm_write_data;
    assign dm_we         = r_dm_we;

endmodule

// File: tb/tb_dm_arb.sv
// Bench for dm_arb: a fair instance with a word memory that commits on the falling edge of dm_we,
// and a fixed-priority instance fed by an address-derived read pattern.
`timescale 1ns/1ps
module tb_dm_arb;
    import dm_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    dm_arb_if a_if();
    dm_arb_if b_if();
    dm_arb_if pa_if();
    dm_arb_if pb_if();

    logic [15:0] f_raddr, f_waddr, p_raddr, p_waddr;
    logic [31:0] f_wdata, f_rdata, p_wdata, p_rdata;
    logic        f_we, p_we;

    dm_arb #(.FAIR(1'b1)) u_fair (
        .clk(clk), .rst(rst), .a_port(a_if), .b_port(b_if),
        .dm_read_addr(f_raddr), .dm_write_addr(f_waddr), .dm_write_data(f_wdata),
        .dm_we(f_we), .dm_read_data(f_rdata)
    );

    dm_arb #(.FAIR(1'b0)) u_pri (
        .clk(clk), .rst(rst), .a_port(pa_if), .b_port(pb_if),
        .dm_read_addr(p_raddr), .dm_write_addr(p_waddr), .dm_write_data(p_wdata),
        .dm_we(p_we), .dm_read_data(p_rdata)
    );

    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];
    assign f_rdata = mem[f_raddr];
    assign p_rdata = {16'hA5A5, p_raddr};

    // Memory commits when dm_we falls; addr/data must not move across that fall.
    logic        prev_we = 1'b0;
    logic [15:0] prev_waddr;
    logic [31:0] prev_wdata;
    int          we_pulses = 0;
    always @(negedge clk) begin
        if (prev_we === 1'b1) begin
            n_checks++;
            if (f_waddr !== prev_waddr || f_wdata !== prev_wdata) begin
                n_fail++;
                $display("FAIL wr_stable: addr/data %h/%h, required %h/%h", f_waddr, f_wdata, prev_waddr, prev_wdata);
            end
            if (f_we === 1'b0) begin
                mem[f_waddr] = f_wdata;
                we_pulses++;
            end
        end
        prev_we    = f_we;
        prev_waddr = f_waddr;
        prev_wdata = f_wdata;
    end

    // Reference state: who won last, and what each port's rdata should be holding.
    bit          exp_last_b;
    logic [31:0] exp_rdata [2];

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input bit p, input logic r, input logic w, input logic [15:0] ad, input logic [31:0] d);
        if (p) begin
            b_if.req = r; b_if.we = w; b_if.addr = ad; b_if.wdata = d;
        end else begin
            a_if.req = r; a_if.we = w; a_if.addr = ad; a_if.wdata = d;
        end
    endtask

    function automatic logic port_gnt(input bit p);
        return p ? b_if.gnt : a_if.gnt;
    endfunction

    function automatic logic [2:0] port_resp(input bit p);
        return p ? {b_if.rvalid, b_if.done, b_if.err} : {a_if.rvalid, a_if.done, a_if.err};
    endfunction

    function automatic logic [31:0] port_rdata(input bit p);
        return p ? b_if.rdata : a_if.rdata;
    endfunction

    function automatic bit addr_ok(input logic [15:0] ad);
        return ad < 16'hFFFD;
    endfunction

    task automatic model_reset();
        exp_last_b   = 1'b1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
    endtask

    task automatic issue(input bit p, input bit w, input logic [15:0] ad, input logic [31:0] d,
                         output int lat, output logic we_k, output logic [2:0] resp, output logic [31:0] rd);
        set_req(p, 1'b1, w, ad, d);
        lat = 0;
        do begin
            step();
            lat++;
        end while (!port_gnt(p) && lat < 20);
        we_k = f_we;
        exp_last_b = p;
        set_req(p, 1'b0, 1'b0, 16'h0, 32'h0);
        step();
        resp = port_resp(p);
        rd   = port_rdata(p);
        step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_checks++;
        if ({a_if.gnt, a_if.rvalid, a_if.done, a_if.err, b_if.gnt, b_if.rvalid, b_if.done, b_if.err} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_pulses: got %b, required 00000000",
                     {a_if.gnt, a_if.rvalid, a_if.done, a_if.err, b_if.gnt, b_if.rvalid, b_if.done, b_if.err});
        end
        n_checks++;
        if ({a_if.rdata, b_if.rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h %h, required 0 0", a_if.rdata, b_if.rdata);
        end
        n_checks++;
        if ({f_we, f_raddr, f_waddr, f_wdata} !== 81'h0) begin
            n_fail++;
            $display("FAIL reset_dm: we %b raddr %h waddr %h wdata %h, required all 0", f_we, f_raddr, f_waddr, f_wdata);
        end
        n_checks++;
        if ({pa_if.gnt, pb_if.gnt, p_we} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_pri: got %b, required 000", {pa_if.gnt, pb_if.gnt, p_we});
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_write_read();
        int lat; logic wk; logic [2:0] resp; logic [31:0] rd; int p0;
        p0 = we_pulses;
        issue(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF, lat, wk, resp, rd);
        ref_mem[16'h0010] = 32'hDEADBEEF;
        n_checks++;
        if (lat !== 1 || wk !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_gnt: latency %0d dm_we %b, required 1 1", lat, wk);
        end
        n_checks++;
        if (resp !== 3'b010) begin
            n_fail++;
            $display("FAIL wr_done: rvalid/done/err %b, required 010", resp);
        end
        n_checks++;
        if (we_pulses - p0 !== 1) begin
            n_fail++;
            $display("FAIL wr_pulses: %0d dm_we pulses, required 1", we_pulses - p0);
        end
        issue(1'b0, 1'b0, 16'h0010, 32'h0, lat, wk, resp, rd);
        exp_rdata[0] = ref_mem[16'h0010];
        n_checks++;
        if (lat !== 1 || resp !== 3'b100 || rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rd_back: latency %0d resp %b rdata %h, required 1 100 deadbeef", lat, resp, rd);
        end
    endtask

    task automatic test_same_cycle_race();
        int t; int lat; logic wk; logic [2:0] resp; logic [31:0] rd; logic [31:0] old;
        rst = 1'b1; step(); step(); rst = 1'b0;
        model_reset();
        old = ref_mem[16'h1234];
        set_req(1'b0, 1'b1, 1'b0, 16'h1234, 32'h0);
        set_req(1'b1, 1'b1, 1'b1, 16'h1234, 32'h00000001);
        t = 0;
        do begin step(); t++; end while (!a_if.gnt && !b_if.gnt && t < 10);
        n_checks++;
        if (a_if.gnt !== 1'b1 || b_if.gnt !== 1'b0 || t !== 1) begin
            n_fail++;
            $display("FAIL race_first: a_gnt %b b_gnt %b after %0d, required 1 0 after 1", a_if.gnt, b_if.gnt, t);
        end
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        step();
        n_checks++;
        if (a_if.rvalid !== 1'b1 || a_if.rdata !== old) begin
            n_fail++;
            $display("FAIL race_old: rvalid %b rdata %h, required 1 %h", a_if.rvalid, a_if.rdata, old);
        end
        t = 0;
        do begin step(); t++; end while (!b_if.gnt && t < 10);
        n_checks++;
        if (t !== 1) begin
            n_fail++;
            $display("FAIL race_b_gnt: b_gnt after %0d cycles, required 1", t);
        end
        set_req(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
        step();
        n_checks++;
        if (b_if.done !== 1'b1) begin
            n_fail++;
            $display("FAIL race_b_done: got %b, required 1", b_if.done);
        end
        step();
        ref_mem[16'h1234] = 32'h00000001;
        issue(1'b0, 1'b0, 16'h1234, 32'h0, lat, wk, resp, rd);
        exp_rdata[0] = 32'h00000001;
        n_checks++;
        if (resp !== 3'b100 || rd !== 32'h00000001) begin
            n_fail++;
            $display("FAIL race_reread: resp %b rdata %h, required 100 00000001", resp, rd);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic wk; logic [2:0] resp; logic [31:0] rd; int p0;
        issue(1'b0, 1'b0, 16'hFFFE, 32'h0, lat, wk, resp, rd);
        n_checks++;
        if (lat !== 1 || resp !== 3'b001 || rd !== exp_rdata[0]) begin
            n_fail++;
            $display("FAIL oor_read: latency %0d resp %b rdata %h, required 1 001 %h", lat, resp, rd, exp_rdata[0]);
        end
        p0 = we_pulses;
        issue(1'b0, 1'b1, 16'hFFFF, $urandom, lat, wk, resp, rd);
        n_checks++;
        if (resp !== 3'b001 || wk !== 1'b0 || we_pulses !== p0) begin
            n_fail++;
            $display("FAIL oor_write: resp %b dm_we %b pulses %0d, required 001 0 0", resp, wk, we_pulses - p0);
        end
        issue(1'b0, 1'b0, 16'hFFFC, 32'h0, lat, wk, resp, rd);
        exp_rdata[0] = ref_mem[16'hFFFC];
        n_checks++;
        if (resp !== 3'b100 || rd !== ref_mem[16'hFFFC]) begin
            n_fail++;
            $display("FAIL last_addr: resp %b rdata %h, required 100 %h", resp, rd, ref_mem[16'hFFFC]);
        end
    endtask

    task automatic test_reset_in_write();
        int t;
        set_req(1'b0, 1'b1, 1'b1, 16'h0020, 32'hCAFEF00D);
        t = 0;
        do begin step(); t++; end while (!a_if.gnt && t < 10);
        n_checks++;
        if (f_we !== 1'b1) begin
            n_fail++;
            $display("FAIL rstwe_we: dm_we %b, required 1", f_we);
        end
        rst = 1'b1;
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        step();
        n_checks++;
        if (f_we !== 1'b0 || f_waddr !== 16'h0020 || f_wdata !== 32'hCAFEF00D || a_if.done !== 1'b0) begin
            n_fail++;
            $display("FAIL rstwe_hold: we %b addr %h data %h done %b, required 0 0020 cafef00d 0", f_we, f_waddr, f_wdata, a_if.done);
        end
        step();
        n_checks++;
        if (mem[16'h0020] !== 32'hCAFEF00D) begin
            n_fail++;
            $display("FAIL rstwe_mem: got %h, required cafef00d", mem[16'h0020]);
        end
        n_checks++;
        if ({a_if.gnt, a_if.done, f_we, f_waddr, f_wdata, a_if.rdata} !== 83'h0) begin
            n_fail++;
            $display("FAIL rstwe_outs: gnt %b done %b we %b addr %h data %h rdata %h, required all 0",
                     a_if.gnt, a_if.done, f_we, f_waddr, f_wdata, a_if.rdata);
        end
        rst = 1'b0;
        ref_mem[16'h0020] = 32'hCAFEF00D;
        model_reset();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d [4];
        int gc [4];
        int idx; int t; int p0;
        for (int i = 0; i < 4; i++) d[i] = $urandom;
        p0 = we_pulses;
        set_req(1'b0, 1'b1, 1'b1, 16'h0000, d[0]);
        idx = 0; t = 0;
        while (idx < 4 && t < 40) begin
            step(); t++;
            if (a_if.gnt) begin
                gc[idx] = cyc;
                idx++;
                if (idx < 4) set_req(1'b0, 1'b1, 1'b1, 16'(idx), d[idx]);
                else         set_req(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
            end
        end
        step(); step();
        exp_last_b = 1'b0;
        n_checks++;
        if (idx !== 4) begin
            n_fail++;
            $display("FAIL b2b_count: %0d grants, required 4", idx);
        end
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (gc[i] - gc[i-1] !== 3) begin
                n_fail++;
                $display("FAIL b2b_spacing: grant %0d after %0d cycles, required 3", i, gc[i] - gc[i-1]);
            end
        end
        n_checks++;
        if (we_pulses - p0 !== 4) begin
            n_fail++;
            $display("FAIL b2b_pulses: %0d dm_we pulses, required 4", we_pulses - p0);
        end
        for (int i = 0; i < 4; i++) begin
            ref_mem[i] = d[i];
            n_checks++;
            if (mem[i] !== d[i]) begin
                n_fail++;
                $display("FAIL b2b_mem: word %0d holds %h, required %h", i, mem[i], d[i]);
            end
        end
    endtask

    task automatic test_fair_contention();
        logic [15:0] ad [2];
        int grants; int t; int pend; logic [31:0] pend_data; bit got; bit want;
        ad[0] = 16'($urandom_range(0, 255));
        ad[1] = 16'($urandom_range(0, 255));
        set_req(1'b0, 1'b1, 1'b0, ad[0], 32'h0);
        set_req(1'b1, 1'b1, 1'b0, ad[1], 32'h0);
        grants = 0; t = 0; pend = -1; pend_data = '0;
        while ((grants < 8 || pend >= 0) && t < 60) begin
            step(); t++;
            if (pend >= 0) begin
                exp_rdata[pend] = pend_data;
                n_checks++;
                if (port_resp(pend[0]) !== 3'b100 || port_rdata(pend[0]) !== pend_data) begin
                    n_fail++;
                    $display("FAIL rr_read: port %0d resp %b rdata %h, required 100 %h", pend, port_resp(pend[0]), port_rdata(pend[0]), pend_data);
                end
                pend = -1;
            end
            if (a_if.gnt && b_if.gnt) begin
                n_checks++; n_fail++;
                $display("FAIL rr_double: both grants high, required one");
            end else if (a_if.gnt || b_if.gnt) begin
                got  = b_if.gnt;
                want = !exp_last_b;
                n_checks++;
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL rr_order: grant %0d went to port %0d, required %0d", grants, got, want);
                end
                exp_last_b = got;
                pend       = int'(got);
                pend_data  = ref_mem[ad[got]];
                grants++;
                ad[got] = 16'($urandom_range(0, 255));
                if (grants >= 8) begin
                    set_req(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
                    set_req(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
                end else begin
                    set_req(got, 1'b1, 1'b0, ad[got], 32'h0);
                end
            end
        end
        n_checks++;
        if (grants !== 8) begin
            n_fail++;
            $display("FAIL rr_count: %0d grants, required 8", grants);
        end
        step();
    endtask

    task automatic test_random();
        bit          pend [2];
        logic        w    [2];
        logic [15:0] ad   [2];
        logic [31:0] d    [2];
        int t; bit got; bit want; bit ok;
        for (int it = 0; it < 25; it++) begin
            for (int p = 0; p < 2; p++) begin
                pend[p] = ($urandom_range(0, 1) == 1);
                w[p]    = ($urandom_range(0, 1) == 1);
                ad[p]   = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF)) : 16'($urandom_range(0, 63));
                d[p]    = $urandom;
            end
            if (!pend[0] && !pend[1]) pend[0] = 1'b1;
            for (int p = 0; p < 2; p++) set_req(p[0], pend[p], w[p], ad[p], d[p]);
            t = 0;
            while ((pend[0] || pend[1]) && t < 20) begin
                step(); t++;
                if (a_if.gnt || b_if.gnt) begin
                    got  = b_if.gnt;
                    want = (pend[0] && pend[1]) ? !exp_last_b : pend[1];
                    ok   = addr_ok(ad[got]);
                    n_checks++;
                    if ((a_if.gnt && b_if.gnt) || got !== want) begin
                        n_fail++;
                        $display("FAIL rnd_grant: a_gnt %b b_gnt %b, required port %0d", a_if.gnt, b_if.gnt, want);
                    end
                    n_checks++;
                    if (f_we !== (w[got] && ok)) begin
                        n_fail++;
                        $display("FAIL rnd_we: dm_we %b, required %b", f_we, w[got] && ok);
                    end
                    exp_last_b = got;
                    pend[got]  = 1'b0;
                    set_req(got, 1'b0, 1'b0, 16'h0, 32'h0);
                    step();
                    if (!w[got] && ok) exp_rdata[got] = ref_mem[ad[got]];
                    n_checks++;
                    if (port_resp(got) !== {!w[got] && ok, w[got] && ok, !ok} || port_rdata(got) !== exp_rdata[got]) begin
                        n_fail++;
                        $display("FAIL rnd_resp: port %0d addr %h resp %b rdata %h, required %b %h", got, ad[got],
                                 port_resp(got), port_rdata(got), {!w[got] && ok, w[got] && ok, !ok}, exp_rdata[got]);
                    end
                    n_checks++;
                    if (port_rdata(!got) !== exp_rdata[!got]) begin
                        n_fail++;
                        $display("FAIL rnd_hold: idle port rdata %h, required %h", port_rdata(!got), exp_rdata[!got]);
                    end
                    if (w[got]) begin
                        if (ok) ref_mem[ad[got]] = d[got];
                        step();
                    end
                end
            end
            n_checks++;
            if (pend[0] || pend[1]) begin
                n_fail++;
                $display("FAIL rnd_timeout: pending a %b b %b, required none", pend[0], pend[1]);
                set_req(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
                set_req(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
                step(); step(); step();
            end
        end
    endtask

    task automatic test_priority();
        int a_cnt; int b_cnt; int t;
        pa_if.req = 1'b1; pa_if.we = 1'b0; pa_if.addr = 16'h0011; pa_if.wdata = '0;
        pb_if.req = 1'b1; pb_if.we = 1'b0; pb_if.addr = 16'h0022; pb_if.wdata = '0;
        a_cnt = 0; b_cnt = 0;
        for (int s = 0; s < 12; s++) begin
            step();
            if (pa_if.gnt) a_cnt++;
            if (pb_if.gnt) b_cnt++;
            if (pa_if.rvalid) begin
                n_checks++;
                if (pa_if.rdata !== 32'hA5A50011) begin
                    n_fail++;
                    $display("FAIL pri_rdata: got %h, required a5a50011", pa_if.rdata);
                end
            end
        end
        n_checks++;
        if (a_cnt !== 6 || b_cnt !== 0) begin
            n_fail++;
            $display("FAIL pri_grants: A %0d B %0d, required 6 0", a_cnt, b_cnt);
        end
        pa_if.req = 1'b0;
        t = 0;
        do begin step(); t++; end while (!pb_if.gnt && t < 10);
        pb_if.req = 1'b0;
        n_checks++;
        if (t !== 1) begin
            n_fail++;
            $display("FAIL pri_b_gnt: after %0d cycles, required 1", t);
        end
        step();
        n_checks++;
        if (pb_if.rvalid !== 1'b1 || pb_if.rdata !== 32'hA5A50022) begin
            n_fail++;
            $display("FAIL pri_b_read: rvalid %b rdata %h, required 1 a5a50022", pb_if.rvalid, pb_if.rdata);
        end
        step();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        set_req(1'b0, 1'b0, 1'b0, 16'h0, 32'h0);
        set_req(1'b1, 1'b0, 1'b0, 16'h0, 32'h0);
        pa_if.req = 1'b0; pa_if.we = 1'b0; pa_if.addr = '0; pa_if.wdata = '0;
        pb_if.req = 1'b0; pb_if.we = 1'b0; pb_if.addr = '0; pb_if.wdata = '0;
        model_reset();

        test_reset();
        test_write_read();
        test_same_cycle_race();
        test_out_of_range();
        test_reset_in_write();
        test_back_to_back();
        test_fair_contention();
        test_random();
        test_priority();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
